// File: rtl/wb_queue.sv
// Writeback queue: two-producer, in-order FIFO retiring to the single register-file write port.
// Define WB_QUEUE_FWD_EN to build the pending-write forwarding lookup; otherwise fwd_* are tied to 0.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [31:0]              mem_data,
    input  logic                     rf_hold,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    input  logic [4:0]               fwd_addr,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    logic          full;
    logic          accept;
    logic          push;
    logic          pop;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;

    // Ready depends on registered count only, so rf_hold never reaches the producers.
    assign full      = (count == CW'(DEPTH));
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;

    assign sel_rd   = mem_valid ? mem_rd   : alu_rd;
    assign sel_data = mem_valid ? mem_data : alu_data;
    assign accept   = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign push     = accept && (sel_rd != 5'd0);
    assign pop      = (count != '0) && !rf_hold;

    assign rf_we    = pop;
    assign rf_waddr = pop ? rd_mem[rptr]   : 5'd0;
    assign rf_wdata = pop ? data_mem[rptr] : 32'd0;
    assign pending  = count;

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wptr]   <= sel_rd;
            data_mem[wptr] <= sel_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef WB_QUEUE_FWD_EN
    // Scan oldest to youngest so the last match wins.
    always_comb begin
        logic [AW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + AW'(i);
            if ((CW'(i) < count) && (fwd_addr != 5'd0) && (rd_mem[idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[idx];
            end
        end
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^fwd_addr;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = 32'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: stimulus queues expected retirements, a monitor checks the write port.
module tb_wb_queue;
`ifdef WB_QUEUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        rf_hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  pending;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_hold(rf_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every retirement must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire", {rf_waddr, rf_wdata}, 37'd0);
            end else begin
                chk("retire", {rf_waddr, rf_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one result; track=0 means the entry is expected to be discarded by reset.
    task automatic do_push(input bit m, input logic [4:0] rd, input logic [31:0] d, input bit track);
        int n;
        n = 0;
        if (m) begin mem_valid = 1'b1; mem_rd = rd; mem_data = d; end
        else   begin alu_valid = 1'b1; alu_rd = rd; alu_data = d; end
        while (!(m ? mem_ready : alu_ready)) begin
            step();
            n++;
            if (n > 50) begin
                chk("push_timeout", 37'd0, 37'd1);
                break;
            end
        end
        if (track && rd != 5'd0) exp_q.push_back({rd, d});
        step();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0; rf_hold = 0; fwd_addr = 0;
        #1;
        chk("rst_we",      {36'd0, rf_we},    37'd0);
        chk("rst_port",    {rf_waddr, rf_wdata}, 37'd0);
        chk("rst_fwd",     {4'd0, fwd_hit, fwd_data}, 37'd0);
        chk("rst_pending", {34'd0, pending},  37'd0);
        chk("rst_ready",   {35'd0, mem_ready, alu_ready}, 37'd3);
        mem_valid = 1'b1;
        #1;
        chk("rst_alu_ready_memv", {35'd0, mem_ready, alu_ready}, 37'd2);
        mem_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // Single ALU push, retires the next cycle.
        do_push(1'b0, 5'd5, 32'h1234_5678, 1'b1);
        chk("lat_we",   {36'd0, rf_we}, 37'd1);
        chk("lat_port", {rf_waddr, rf_wdata}, {5'd5, 32'h1234_5678});
        step();
        chk("lat_pending_after", {34'd0, pending}, 37'd0);

        // Simultaneous producers: load wins, ALU next cycle.
        mem_valid = 1; mem_rd = 5'd3; mem_data = 32'h33;
        alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44;
        #1;
        chk("arb_ready", {35'd0, mem_ready, alu_ready}, 37'd2);
        exp_q.push_back({5'd3, 32'h33});
        step();
        mem_valid = 0;
        #1;
        chk("arb_alu_next", {36'd0, alu_ready}, 37'd1);
        exp_q.push_back({5'd4, 32'h44});
        step();
        alu_valid = 0;
        step(); step();
        chk("arb_drained", {34'd0, pending}, 37'd0);

        // Fill under hold, fifth push stalls, then drain in order.
        rf_hold = 1;
        for (int i = 1; i <= 4; i++) do_push(1'b0, 5'(i), 32'h100 + 32'(i), 1'b1);
        chk("full_pending", {34'd0, pending}, 37'd4);
        chk("full_ready",   {35'd0, mem_ready, alu_ready}, 37'd0);
        alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h999;
        step(); step();
        chk("stall_pending", {34'd0, pending}, 37'd4);
        rf_hold = 0;
        #1;
        chk("full_pop_refuse", {36'd0, alu_ready}, 37'd0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_we", {36'd0, rf_we}, 37'd1);
            step();
            alu_valid = 0;
        end
        chk("drain_pending", {34'd0, pending}, 37'd0);

        // x0 writes are consumed without being queued.
        do_push(1'b0, 5'd0, 32'hDEAD, 1'b1);
        chk("x0_pending", {34'd0, pending}, 37'd0);
        chk("x0_we", {36'd0, rf_we}, 37'd0);
        step(); step();

        // Forwarding: same-cycle push invisible, youngest match wins, head included.
        rf_hold = 1; fwd_addr = 5'd7;
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'hA;
        #1;
        chk("fwd_same_cycle", {4'd0, fwd_hit, fwd_data}, 37'd0);
        exp_q.push_back({5'd7, 32'hA});
        step();
        alu_valid = 0;
        do_push(1'b0, 5'd7, 32'hB, 1'b1);
        chk("fwd_young", {4'd0, fwd_hit, fwd_data}, FWD ? {5'd1, 32'hB} : 37'd0);
        fwd_addr = 5'd8;
        #1;
        chk("fwd_miss", {4'd0, fwd_hit, fwd_data}, 37'd0);
        fwd_addr = 5'd0;
        #1;
        chk("fwd_x0", {4'd0, fwd_hit, fwd_data}, 37'd0);
        fwd_addr = 5'd7; rf_hold = 0;
        #1;
        chk("fwd_head_retiring", {4'd0, fwd_hit, fwd_data}, FWD ? {5'd1, 32'hB} : 37'd0);
        step();
        chk("fwd_last", {4'd0, fwd_hit, fwd_data}, FWD ? {5'd1, 32'hB} : 37'd0);
        step();
        chk("fwd_empty", {4'd0, fwd_hit, fwd_data}, 37'd0);

        // Asynchronous reset with entries queued; none may retire afterwards.
        rf_hold = 1;
        for (int i = 0; i < 3; i++) do_push(1'b1, 5'd20 + 5'(i), 32'hBAD0 + 32'(i), 1'b0);
        chk("pre_rst_pending", {34'd0, pending}, 37'd3);
        #2;
        rst = 1;
        #1;
        chk("midrst_pending", {34'd0, pending}, 37'd0);
        chk("midrst_we", {36'd0, rf_we}, 37'd0);
        chk("midrst_ready", {35'd0, mem_ready, alu_ready}, 37'd3);
        step();
        rst = 0; rf_hold = 0;
        for (int k = 0; k < 5; k++) step();
        chk("post_rst_pending", {34'd0, pending}, 37'd0);
        chk("scoreboard_empty", 37'(exp_q.size()), 37'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
